// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: phase FSM, frame-derived move tick, turn arbitration, length/score/speed tracking.
// Optional feature macro SNAKE_PAUSE_EN adds a pause input whose pulses toggle a freeze of PLAY.
module snake_game_ctrl #(
    parameter int unsigned FRAMES_PER_MOVE = 6,
    parameter int unsigned MIN_FRAMES      = 2,
    parameter int unsigned SPEEDUP_EVERY   = 4,
    parameter int unsigned MAX_LEN         = 15,
    parameter int unsigned LEN_W           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             start,
    input  logic             dir_valid,
    input  logic [3:0]       dir_code,
    input  logic             ate_food,
    input  logic             collision,
`ifdef SNAKE_PAUSE_EN
    input  logic             pause,
`endif
    output logic [1:0]       state,
    output logic             move_tick,
    output logic [3:0]       dir_out,
    output logic [LEN_W-1:0] snake_len,
    output logic [15:0]      score,
    output logic             game_over,
    output logic             win_game,
    output logic             food_respawn
);

    localparam int unsigned FC_W    = 8;
    localparam int unsigned EAT_W   = 16;
    localparam int unsigned SCORE_W = 16;

    localparam logic [FC_W-1:0]    PERIOD_INIT = FC_W'(FRAMES_PER_MOVE);
    localparam logic [FC_W-1:0]    PERIOD_MIN  = FC_W'(MIN_FRAMES);
    localparam logic [EAT_W-1:0]   EAT_WRAP    = EAT_W'(SPEEDUP_EVERY);
    localparam logic [LEN_W-1:0]   LEN_MAX     = LEN_W'(MAX_LEN);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
    localparam logic [3:0]         DIR_RIGHT   = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2,
        S_WIN  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [FC_W-1:0]    period_q, period_d;
    logic [EAT_W-1:0]   eat_cnt_q, eat_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         dir_q, dir_d;
    logic [3:0]         pend_q, pend_d;
    logic               tick_q, tick_d;
    logic               resp_q, resp_d;
    logic               over_q, over_d;
    logic               win_q, win_d;

    logic               frozen;
    logic               frame_hit;
    logic               dir_onehot;
    logic               dir_ok;
    logic [3:0]         dir_rev;
    logic [EAT_W-1:0]   eat_inc;

`ifdef SNAKE_PAUSE_EN
    logic pause_q, pause_d;
    assign frozen = pause_q;
`else
    assign frozen = 1'b0;
`endif

    // Reverse of a one-hot direction: swaps up<->down and left<->right.
    assign dir_rev    = {dir_q[1:0], dir_q[3:2]};
    assign dir_onehot = (dir_code != 4'd0) && ((dir_code & (dir_code - 4'd1)) == 4'd0);
    assign dir_ok     = dir_valid && dir_onehot && (dir_code != dir_q) && (dir_code != dir_rev);
    // >= keeps the counter bounded if a speed-up shortens the period mid-count.
    assign frame_hit  = (frame_cnt_q >= (period_q - FC_W'(1)));
    assign eat_inc    = eat_cnt_q + EAT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            period_q    <= PERIOD_INIT;
            eat_cnt_q   <= '0;
            len_q       <= '0;
            score_q     <= '0;
            dir_q       <= '0;
            pend_q      <= '0;
            tick_q      <= 1'b0;
            resp_q      <= 1'b0;
            over_q      <= 1'b0;
            win_q       <= 1'b0;
`ifdef SNAKE_PAUSE_EN
            pause_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            period_q    <= period_d;
            eat_cnt_q   <= eat_cnt_d;
            len_q       <= len_d;
            score_q     <= score_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            tick_q      <= tick_d;
            resp_q      <= resp_d;
            over_q      <= over_d;
            win_q       <= win_d;
`ifdef SNAKE_PAUSE_EN
            pause_q     <= pause_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        period_d    = period_q;
        eat_cnt_d   = eat_cnt_q;
        len_d       = len_q;
        score_d     = score_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        tick_d      = 1'b0;
        resp_d      = 1'b0;
`ifdef SNAKE_PAUSE_EN
        pause_d     = pause_q;
`endif

        unique case (state_q)
            S_PLAY: begin
`ifdef SNAKE_PAUSE_EN
                if (pause) begin
                    pause_d = ~pause_q;
                end
`endif
                if (!frozen) begin
                    // Collision dominates a same-cycle eat.
                    if (collision) begin
                        state_d = S_OVER;
                    end else if (ate_food) begin
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        if (len_q < LEN_MAX) begin
                            len_d = len_q + LEN_W'(1);
                        end
                        if (eat_inc >= EAT_WRAP) begin
                            eat_cnt_d = '0;
                            if (period_q > PERIOD_MIN) begin
                                period_d = period_q - FC_W'(1);
                            end
                        end else begin
                            eat_cnt_d = eat_inc;
                        end
                        if (len_d == LEN_MAX) begin
                            state_d = S_WIN;
                        end else begin
                            resp_d = 1'b1;
                        end
                    end

                    if (frame_start) begin
                        if (frame_hit) begin
                            frame_cnt_d = '0;
                            if (state_d == S_PLAY) begin
                                tick_d = 1'b1;
                                if (pend_q != 4'd0) begin
                                    dir_d  = pend_q;
                                    pend_d = '0;
                                end
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + FC_W'(1);
                        end
                    end

                    // A fresh request lands after any commit so the latest one wins.
                    if (dir_ok) begin
                        pend_d = dir_code;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d     = S_PLAY;
                    len_d       = '0;
                    score_d     = '0;
                    period_d    = PERIOD_INIT;
                    frame_cnt_d = '0;
                    dir_d       = DIR_RIGHT;
                    pend_d      = '0;
                end
            end
        endcase

`ifdef SNAKE_PAUSE_EN
        if (state_d != S_PLAY) begin
            pause_d = 1'b0;
        end
`endif
        over_d = (state_d == S_OVER);
        win_d  = (state_d == S_WIN);
    end

    assign state        = state_q;
    assign move_tick    = tick_q;
    assign dir_out      = dir_q;
    assign snake_len    = len_q;
    assign score        = score_q;
    assign game_over    = over_q;
    assign win_game     = win_q;
    assign food_respawn = resp_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed scenarios plus a randomized run against a game-rules model.
module tb_snake_game_ctrl;

    localparam int FPM  = 6;
    localparam int MINF = 2;
    localparam int SPD  = 4;
    localparam int MAXL = 15;
    localparam int LW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          start = 1'b0;
    logic          dir_valid = 1'b0;
    logic [3:0]    dir_code = 4'd0;
    logic          ate_food = 1'b0;
    logic          collision = 1'b0;
`ifdef SNAKE_PAUSE_EN
    logic          pause = 1'b0;
`endif
    logic [1:0]    state;
    logic          move_tick;
    logic [3:0]    dir_out;
    logic [LW-1:0] snake_len;
    logic [15:0]   score;
    logic          game_over;
    logic          win_game;
    logic          food_respawn;
    logic [30:0]   obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Game-rules model: phase 0 idle, 1 play, 2 over, 3 win.
    int       m_phase, m_frames, m_period, m_eats, m_len, m_score;
    bit [3:0] m_dir, m_pend;
    bit       m_tick, m_resp;

    snake_game_ctrl #(
        .FRAMES_PER_MOVE(FPM), .MIN_FRAMES(MINF), .SPEEDUP_EVERY(SPD),
        .MAX_LEN(MAXL), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .start(start),
        .dir_valid(dir_valid), .dir_code(dir_code), .ate_food(ate_food),
        .collision(collision),
`ifdef SNAKE_PAUSE_EN
        .pause(pause),
`endif
        .state(state), .move_tick(move_tick), .dir_out(dir_out),
        .snake_len(snake_len), .score(score), .game_over(game_over),
        .win_game(win_game), .food_respawn(food_respawn)
    );

    always #5 clk = ~clk;

    assign obs = {state, move_tick, dir_out, snake_len, score, game_over, win_game, food_respawn};

    function automatic bit [3:0] opposite(input bit [3:0] d);
        case (d)
            4'b0001: return 4'b0100;
            4'b0100: return 4'b0001;
            4'b0010: return 4'b1000;
            4'b1000: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [30:0] expected_vec();
        return {m_phase[1:0], m_tick, m_dir, m_len[LW-1:0], m_score[15:0],
                (m_phase == 2), (m_phase == 3), m_resp};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_frames = 0; m_period = FPM; m_eats = 0; m_len = 0; m_score = 0;
        m_dir = 4'd0; m_pend = 4'd0; m_tick = 1'b0; m_resp = 1'b0;
    endtask

    task automatic model_step();
        int       nphase     = m_phase;
        int       old_period = m_period;
        bit [3:0] old_dir    = m_dir;
        bit       accept;
        m_tick = 1'b0;
        m_resp = 1'b0;
        if (m_phase != 1) begin
            if (start) begin
                nphase = 1; m_len = 0; m_score = 0; m_period = FPM; m_frames = 0;
                m_dir = 4'b1000; m_pend = 4'd0;
            end
        end else begin
            accept = dir_valid && ($countones(dir_code) == 1) && (dir_code != old_dir)
                     && (dir_code != opposite(old_dir));
            if (collision) begin
                nphase = 2;
            end else if (ate_food) begin
                if (m_score < 65535) m_score++;
                if (m_len < MAXL) m_len++;
                m_eats++;
                if (m_eats == SPD) begin
                    m_eats = 0;
                    if (m_period > MINF) m_period--;
                end
                if (m_len == MAXL) nphase = 3;
                else m_resp = 1'b1;
            end
            if (frame_start) begin
                m_frames++;
                if (m_frames >= old_period) begin
                    m_frames = 0;
                    if (nphase == 1) begin
                        m_tick = 1'b1;
                        if (m_pend != 4'd0) begin
                            m_dir  = m_pend;
                            m_pend = 4'd0;
                        end
                    end
                end
            end
            if (accept) m_pend = dir_code;
        end
        m_phase = nphase;
    endtask

    // One clock: DUT and model both see the driven inputs, then pulses are dropped.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        frame_start = 1'b0; start = 1'b0; dir_valid = 1'b0; dir_code = 4'd0;
        ate_food = 1'b0; collision = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if (obs !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 31'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (obs !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected %h", obs, 31'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_checks++;
        if (obs !== expected_vec()) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got %h expected %h", obs, expected_vec());
        end
    endtask

    task automatic test_first_tick();
        int ticks = 0;
        apply_reset();
        start = 1'b1;
        step();
        n_checks++;
        if (state !== 2'd1 || dir_out !== 4'b1000) begin
            n_fail++;
            $display("FAIL start_play: got state %0d dir %b expected state 1 dir 1000", state, dir_out);
        end
        for (int f = 1; f <= 6; f++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                ticks += int'(move_tick);
                n_checks++;
                if (obs !== expected_vec()) begin
                    n_fail++;
                    $display("FAIL first_tick_gap: got %h expected %h", obs, expected_vec());
                end
            end
            frame_start = 1'b1;
            step();
            if (f < 6) ticks += int'(move_tick);
            n_checks++;
            if (obs !== expected_vec()) begin
                n_fail++;
                $display("FAIL first_tick_frame%0d: got %h expected %h", f, obs, expected_vec());
            end
        end
        n_checks++;
        if (move_tick !== 1'b1 || ticks != 0) begin
            n_fail++;
            $display("FAIL first_tick_sixth: got tick %b early %0d expected tick 1 early 0", move_tick, ticks);
        end
        step();
        n_checks++;
        if (move_tick !== 1'b0 || dir_out !== 4'b1000) begin
            n_fail++;
            $display("FAIL first_tick_width: got tick %b dir %b expected 0 1000", move_tick, dir_out);
        end
    endtask

    task automatic test_direction();
        apply_reset();
        start = 1'b1;
        step();
        dir_valid = 1'b1; dir_code = 4'b0010;
        step();
        dir_valid = 1'b1; dir_code = 4'b0001;
        step();
        dir_valid = 1'b1; dir_code = 4'b0100;
        step();
        for (int f = 0; f < 6; f++) begin
            frame_start = 1'b1;
            step();
            n_checks++;
            if (obs !== expected_vec()) begin
                n_fail++;
                $display("FAIL direction_frame%0d: got %h expected %h", f, obs, expected_vec());
            end
        end
        n_checks++;
        if (move_tick !== 1'b1 || dir_out !== 4'b0100) begin
            n_fail++;
            $display("FAIL direction_commit: got tick %b dir %b expected 1 0100", move_tick, dir_out);
        end
    endtask

    task automatic test_eat_speed();
        int         resp = 0;
        logic [9:0] tick_map = '0;
        apply_reset();
        start = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            ate_food = 1'b1;
            step();
            resp += int'(food_respawn);
            step();
            n_checks++;
            if (obs !== expected_vec()) begin
                n_fail++;
                $display("FAIL eat_%0d: got %h expected %h", i, obs, expected_vec());
            end
        end
        n_checks++;
        if (snake_len !== 5'd4 || score !== 16'd4 || resp != 4) begin
            n_fail++;
            $display("FAIL eat_totals: got len %0d score %0d resp %0d expected 4 4 4", snake_len, score, resp);
        end
        for (int f = 0; f < 10; f++) begin
            frame_start = 1'b1;
            step();
            tick_map[f] = move_tick;
            step();
        end
        n_checks++;
        if (tick_map !== 10'b10_0001_0000) begin
            n_fail++;
            $display("FAIL speedup_period: got %b expected %b", tick_map, 10'b10_0001_0000);
        end
    endtask

    task automatic test_collision_eat();
        int ticks = 0;
        apply_reset();
        start = 1'b1;
        step();
        repeat (2) begin
            ate_food = 1'b1;
            step();
        end
        ate_food = 1'b1; collision = 1'b1;
        step();
        n_checks++;
        if (state !== 2'd2 || game_over !== 1'b1 || snake_len !== 5'd2 || food_respawn !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_wins: got st %0d go %b len %0d resp %b expected 2 1 2 0",
                     state, game_over, snake_len, food_respawn);
        end
        for (int f = 0; f < 8; f++) begin
            frame_start = 1'b1; ate_food = f[0]; dir_valid = 1'b1; dir_code = 4'b0001;
            step();
            ticks += int'(move_tick);
        end
        n_checks++;
        if (ticks != 0 || snake_len !== 5'd2 || score !== 16'd2 || obs !== expected_vec()) begin
            n_fail++;
            $display("FAIL over_frozen: got ticks %0d obs %h expected 0 %h", ticks, obs, expected_vec());
        end
    endtask

    task automatic test_win();
        apply_reset();
        start = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            ate_food = 1'b1;
            step();
        end
        n_checks++;
        if (state !== 2'd3 || win_game !== 1'b1 || snake_len !== 5'd15 || food_respawn !== 1'b0) begin
            n_fail++;
            $display("FAIL win_reached: got st %0d win %b len %0d resp %b expected 3 1 15 0",
                     state, win_game, snake_len, food_respawn);
        end
        start = 1'b1;
        step();
        n_checks++;
        if (state !== 2'd1 || snake_len !== 5'd0 || score !== 16'd0 || win_game !== 1'b0) begin
            n_fail++;
            $display("FAIL win_restart: got st %0d len %0d score %0d win %b expected 1 0 0 0",
                     state, snake_len, score, win_game);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start = 1'b1;
        step();
        repeat (3) begin
            frame_start = 1'b1;
            step();
        end
        ate_food = 1'b1;
        step();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== 31'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", obs, 31'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        start = 1'b1;
        step();
        for (int f = 1; f <= 6; f++) begin
            frame_start = 1'b1;
            step();
            n_checks++;
            if (move_tick !== (f == 6) || obs !== expected_vec()) begin
                n_fail++;
                $display("FAIL post_reset_frame%0d: got %h expected %h", f, obs, expected_vec());
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            start       = ($urandom_range(0, 39) == 0);
            frame_start = ($urandom_range(0, 2) == 0);
            ate_food    = ($urandom_range(0, 14) == 0);
            collision   = ($urandom_range(0, 149) == 0);
            dir_valid   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) dir_code = 4'(1 << $urandom_range(0, 3));
            else dir_code = 4'($urandom_range(0, 15));
            step();
            n_checks++;
            if (obs !== expected_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", c, obs, expected_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_direction();
        test_eat_speed();
        test_collision_eat();
        test_win();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
